// File: rtl/psum_acc_pkg.sv
// Shared definitions for the partial-sum accumulation buffer:
// FSM state encoding, lane-slice offset helper and saturation bounds.
package psum_acc_pkg;

    typedef enum logic [1:0] {
        S_ACC   = 2'd0,
        S_FLUSH = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Bit offset of lane 'lane' inside a packed vector of 'width'-bit lanes.
    function automatic int lane_lo(input int lane, input int width);
        return lane * width;
    endfunction

    // Largest signed value of a 'width'-bit accumulator, zero-extended to 64 bits.
    function automatic logic [63:0] sat_max64(input int width);
        return (64'd1 << (width - 1)) - 64'd1;
    endfunction

    // Smallest signed value of a 'width'-bit accumulator; the low 'width' bits are 100..0.
    function automatic logic [63:0] sat_min64(input int width);
        return ~sat_max64(width);
    endfunction

endpackage

// File: rtl/psum_lane_adder.sv
// One accumulator lane: overwrite (clear) or add a sign-extended psum.
// With PSUM_ACC_SAT_EN defined the add saturates and reports it on 'sat';
// otherwise the add wraps and 'sat' is constant 0.
module psum_lane_adder
    import psum_acc_pkg::*;
#(
    parameter int PSUM_WIDTH = 24,
    parameter int ACC_WIDTH  = 32
) (
    input  logic                  clear,
    input  logic [ACC_WIDTH-1:0]  old_val,
    input  logic [PSUM_WIDTH-1:0] psum_val,
    output logic [ACC_WIDTH-1:0]  result,
    output logic                  sat
);

    logic [ACC_WIDTH-1:0] ext;
    logic [ACC_WIDTH-1:0] sum;

    assign ext = ACC_WIDTH'($signed(psum_val));
    assign sum = old_val + ext;

`ifdef PSUM_ACC_SAT_EN
    localparam logic [63:0]          MAX64   = sat_max64(ACC_WIDTH);
    localparam logic [63:0]          MIN64   = sat_min64(ACC_WIDTH);
    localparam logic [ACC_WIDTH-1:0] ACC_MAX = MAX64[ACC_WIDTH-1:0];
    localparam logic [ACC_WIDTH-1:0] ACC_MIN = MIN64[ACC_WIDTH-1:0];

    logic ovf;
    // Signed overflow: operands agree in sign but the sum does not.
    assign ovf = (old_val[ACC_WIDTH-1] == ext[ACC_WIDTH-1]) &&
                 (sum[ACC_WIDTH-1] != old_val[ACC_WIDTH-1]);
`endif

    // Select overwrite, plain add, or clamped add.
    always_comb begin
        result = sum;
        sat    = 1'b0;
        if (clear) begin
            result = ext;
        end
`ifdef PSUM_ACC_SAT_EN
        else if (ovf) begin
            sat    = 1'b1;
            result = old_val[ACC_WIDTH-1] ? ACC_MIN : ACC_MAX;
        end
`endif
    end

endmodule

// File: rtl/psum_accum_buffer.sv
// Partial-sum accumulation buffer: DEPTH entries of ARRAY_DIM signed lanes.
// Two-stage read-modify-write (read at accept, add+write next cycle) with
// forwarding of the previous write so back-to-back beats to one entry stay
// exact at full rate. Rows are streamed out through a valid/ready drain port.
// Optional feature macro: PSUM_ACC_SAT_EN (saturating lane adds, sticky sat_flag).
module psum_accum_buffer
    import psum_acc_pkg::*;
#(
    parameter  int ARRAY_DIM  = 16,
    parameter  int PSUM_WIDTH = 24,
    parameter  int ACC_WIDTH  = 32,
    parameter  int DEPTH      = 64,
    localparam int AW         = $clog2(DEPTH)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            psum_valid,
    output logic                            psum_ready,
    input  logic                            psum_clear,
    input  logic [AW-1:0]                   psum_addr,
    input  logic [ARRAY_DIM*PSUM_WIDTH-1:0] psum_data,
    input  logic                            drain_start,
    input  logic [AW-1:0]                   drain_base,
    input  logic [AW:0]                     drain_len,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [AW-1:0]                   out_addr,
    output logic [ARRAY_DIM*ACC_WIDTH-1:0]  out_data,
    output logic                            drain_done,
    output logic                            busy,
    output logic                            sat_flag
);

    localparam int            DW      = ARRAY_DIM * ACC_WIDTH;
    localparam logic [AW:0]   CNT_ONE = {{AW{1'b0}}, 1'b1};

    state_t state_q, state_d;

    // Stage-2 beat registers (captured at accept).
    logic                            s2_valid_q;
    logic                            s2_clear_q;
    logic [AW-1:0]                   s2_addr_q;
    logic [ARRAY_DIM*PSUM_WIDTH-1:0] s2_data_q;

    // Copy of the last write, used when the RAM read raced that write.
    logic                            fwd_valid_q;
    logic [AW-1:0]                   fwd_addr_q;
    logic [DW-1:0]                   fwd_data_q;

    // Drain bookkeeping.
    logic [AW-1:0]                   base_q;
    logic [AW:0]                     len_q;
    logic [AW:0]                     issue_q;
    logic                            ovalid_q;
    logic [AW-1:0]                   oaddr_q;
    logic                            sat_q;

    // Buffer storage and its registered read port.
    logic [DW-1:0]                   mem [DEPTH];
    logic [DW-1:0]                   rd_q;

    logic                            accept;
    logic                            drain_go;
    logic                            drain_issue;
    logic [AW-1:0]                   rd_addr;
    logic                            rd_en;
    logic [DW-1:0]                   old_vec;
    logic [DW-1:0]                   res_vec;
    logic [ARRAY_DIM-1:0]            sat_vec;

    assign psum_ready = (state_q == S_ACC);
    assign accept     = psum_valid & psum_ready;
    assign drain_go   = drain_start & (state_q == S_ACC);
    assign rd_addr    = (state_q == S_DRAIN) ? (base_q + issue_q[AW-1:0]) : psum_addr;
    assign rd_en      = accept | drain_issue;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_ACC;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and drain read issue; one read outstanding at most,
    // and the next read is only issued when the held beat is free or leaving.
    always_comb begin
        state_d     = state_q;
        drain_issue = 1'b0;
        case (state_q)
            S_ACC: begin
                if (drain_go) begin
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (!s2_valid_q) begin
                    state_d = (len_q == '0) ? S_DONE : S_DRAIN;
                end
            end
            S_DRAIN: begin
                drain_issue = (issue_q != len_q) && (!ovalid_q || out_ready);
                if (ovalid_q && out_ready && (issue_q == len_q)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_ACC;
            end
            default: begin
                state_d = S_ACC;
            end
        endcase
    end

    // Stage-1 capture of accepted beats.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            s2_clear_q <= 1'b0;
            s2_addr_q  <= '0;
            s2_data_q  <= '0;
        end else begin
            s2_valid_q <= accept;
            if (accept) begin
                s2_clear_q <= psum_clear;
                s2_addr_q  <= psum_addr;
                s2_data_q  <= psum_data;
            end
        end
    end

    // RAM: stage-2 write port and registered read port (read returns pre-write data).
    always_ff @(posedge clk) begin
        if (s2_valid_q) begin
            mem[s2_addr_q] <= res_vec;
        end
        if (rd_en) begin
            rd_q <= mem[rd_addr];
        end
    end

    // Remember the write just performed so the following beat can bypass the RAM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fwd_valid_q <= 1'b0;
            fwd_addr_q  <= '0;
            fwd_data_q  <= '0;
        end else begin
            fwd_valid_q <= s2_valid_q;
            if (s2_valid_q) begin
                fwd_addr_q <= s2_addr_q;
                fwd_data_q <= res_vec;
            end
        end
    end

    assign old_vec = (fwd_valid_q && (fwd_addr_q == s2_addr_q)) ? fwd_data_q : rd_q;

    generate
        for (genvar gi = 0; gi < ARRAY_DIM; gi++) begin : g_lane
            localparam int PLO = lane_lo(gi, PSUM_WIDTH);
            localparam int ALO = lane_lo(gi, ACC_WIDTH);
            psum_lane_adder #(
                .PSUM_WIDTH (PSUM_WIDTH),
                .ACC_WIDTH  (ACC_WIDTH)
            ) u_lane_adder (
                .clear    (s2_clear_q),
                .old_val  (old_vec[ALO +: ACC_WIDTH]),
                .psum_val (s2_data_q[PLO +: PSUM_WIDTH]),
                .result   (res_vec[ALO +: ACC_WIDTH]),
                .sat      (sat_vec[gi])
            );
        end
    endgenerate

    // Drain window capture, read counter and output-beat holding register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q   <= '0;
            len_q    <= '0;
            issue_q  <= '0;
            ovalid_q <= 1'b0;
            oaddr_q  <= '0;
        end else begin
            if (drain_go) begin
                base_q  <= drain_base;
                len_q   <= drain_len;
                issue_q <= '0;
            end
            if (drain_issue) begin
                issue_q  <= issue_q + CNT_ONE;
                oaddr_q  <= rd_addr;
                ovalid_q <= 1'b1;
            end else if (out_ready) begin
                ovalid_q <= 1'b0;
            end
        end
    end

    // Sticky saturation flag; a saturating beat in flight wins over the clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_q <= 1'b0;
        end else begin
            sat_q <= (sat_q & ~drain_go) | (s2_valid_q & (|sat_vec));
        end
    end

    assign out_valid  = ovalid_q;
    assign out_addr   = oaddr_q;
    assign out_data   = ovalid_q ? rd_q : '0;
    assign drain_done = (state_q == S_DONE);
    assign busy       = (state_q != S_ACC) | s2_valid_q;
    assign sat_flag   = sat_q;

endmodule

// File: tb/tb_psum_accum_buffer.sv
// Self-checking bench for psum_accum_buffer with a lane-level reference model.
// Honours PSUM_ACC_SAT_EN for the expected arithmetic and sat_flag.
module tb_psum_accum_buffer;

    localparam int AD    = 16;
    localparam int PW    = 24;
    localparam int ACW   = 32;
    localparam int DEPTH = 64;
    localparam int AW    = 6;

    logic               clk;
    logic               rst;
    logic               psum_valid;
    logic               psum_ready;
    logic               psum_clear;
    logic [AW-1:0]      psum_addr;
    logic [AD*PW-1:0]   psum_data;
    logic               drain_start;
    logic [AW-1:0]      drain_base;
    logic [AW:0]        drain_len;
    logic               out_valid;
    logic               out_ready;
    logic [AW-1:0]      out_addr;
    logic [AD*ACW-1:0]  out_data;
    logic               drain_done;
    logic               busy;
    logic               sat_flag;

    int n_checks = 0;
    int n_pass   = 0;

    logic [ACW-1:0]    model [DEPTH][AD];
    logic [AD*ACW-1:0] last_data;

    psum_accum_buffer #(
        .ARRAY_DIM  (AD),
        .PSUM_WIDTH (PW),
        .ACC_WIDTH  (ACW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .psum_valid  (psum_valid),
        .psum_ready  (psum_ready),
        .psum_clear  (psum_clear),
        .psum_addr   (psum_addr),
        .psum_data   (psum_data),
        .drain_start (drain_start),
        .drain_base  (drain_base),
        .drain_len   (drain_len),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_addr    (out_addr),
        .out_data    (out_data),
        .drain_done  (drain_done),
        .busy        (busy),
        .sat_flag    (sat_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Reference lane arithmetic straight from the accumulation rules.
    function automatic logic [ACW-1:0] lane_update(input logic [ACW-1:0] old,
                                                   input logic clr,
                                                   input logic [PW-1:0] p);
        longint e;
        longint s;
        e = longint'($signed(p));
        s = longint'($signed(old)) + e;
        if (clr) return ACW'(e);
`ifdef PSUM_ACC_SAT_EN
        begin
            longint maxv;
            longint minv;
            maxv = (longint'(1) <<< (ACW - 1)) - 1;
            minv = -(longint'(1) <<< (ACW - 1));
            if (s > maxv) s = maxv;
            if (s < minv) s = minv;
        end
`endif
        return s[ACW-1:0];
    endfunction

    function automatic logic [AD*ACW-1:0] exp_vec(input logic [AW-1:0] a);
        logic [AD*ACW-1:0] v;
        for (int l = 0; l < AD; l++) v[l*ACW +: ACW] = model[a][l];
        return v;
    endfunction

    function automatic logic [AD*PW-1:0] rep(input logic [PW-1:0] v);
        return {AD{v}};
    endfunction

    function automatic logic [AD*PW-1:0] rnd_data();
        logic [AD*PW-1:0] d;
        for (int l = 0; l < AD; l++) d[l*PW +: PW] = PW'($urandom);
        return d;
    endfunction

    task automatic apply_beat(input logic [AW-1:0] a, input logic clr, input logic [AD*PW-1:0] d);
        for (int l = 0; l < AD; l++) model[a][l] = lane_update(model[a][l], clr, d[l*PW +: PW]);
    endtask

    // Present one beat for the next rising edge; valid stays high for back-to-back use.
    task automatic send_beat(input logic [AW-1:0] a, input logic clr, input logic [AD*PW-1:0] d);
        @(negedge clk);
        psum_valid = 1'b1;
        psum_addr  = a;
        psum_clear = clr;
        psum_data  = d;
        apply_beat(a, clr, d);
    endtask

    task automatic idle();
        @(negedge clk);
        psum_valid = 1'b0;
    endtask

    // Collect drain beats after drain_start was presented, checking order, data and hold.
    task automatic run_drain(input int base, input int len, input bit rnd);
        int got;
        bit done;
        bit held;
        int extra;
        logic [AW-1:0]     ea;
        logic [AW-1:0]     pa;
        logic [AD*ACW-1:0] pd;
        got = 0; done = 1'b0; held = 1'b0; pa = '0; pd = '0;
        for (int cyc = 0; cyc < 600 && !done; cyc++) begin
            @(negedge clk);
            drain_start = 1'b0;
            if (drain_done) begin
                done = 1'b1;
                n_checks++;
                if (got !== len) $display("FAIL drain_beat_count got=%0d exp=%0d", got, len);
                else n_pass++;
                n_checks++;
                if (out_valid !== 1'b0) $display("FAIL done_out_valid got=%0b exp=0", out_valid);
                else n_pass++;
            end else begin
                if (held) begin
                    n_checks++;
                    if ({out_valid, out_addr, out_data} !== {1'b1, pa, pd})
                        $display("FAIL hold_stable got=%0b/%0d exp=1/%0d", out_valid, out_addr, pa);
                    else n_pass++;
                end
                out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                if (out_valid && out_ready) begin
                    ea = AW'(base + got);
                    n_checks++;
                    if ({out_addr, out_data} !== {ea, exp_vec(ea)})
                        $display("FAIL drain_beat addr got=%0d exp=%0d data got=%h exp=%h",
                                 out_addr, ea, out_data, exp_vec(ea));
                    else n_pass++;
                    $display("drain beat %0d addr=%0d lane0=%h", got, out_addr, out_data[ACW-1:0]);
                    last_data = out_data;
                    got++;
                end
                held = out_valid && !out_ready;
                pa   = out_addr;
                pd   = out_data;
            end
        end
        n_checks++;
        if (!done) $display("FAIL drain_timeout got=%0d exp=done", got);
        else n_pass++;
        extra = 0;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (drain_done || !psum_ready) extra++;
        end
        n_checks++;
        if (extra !== 0) $display("FAIL after_done extra_cycles got=%0d exp=0", extra);
        else n_pass++;
    endtask

    task automatic do_drain(input int base, input int len, input bit rnd);
        @(negedge clk);
        psum_valid  = 1'b0;
        drain_start = 1'b1;
        drain_base  = AW'(base);
        drain_len   = (AW+1)'(len);
        $display("drain start base=%0d len=%0d", base, len);
        run_drain(base, len, rnd);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (psum_ready !== 1'b1) $display("FAIL reset_psum_ready got=%0b exp=1", psum_ready); else n_pass++;
        n_checks++; if (out_valid !== 1'b0)  $display("FAIL reset_out_valid got=%0b exp=0", out_valid); else n_pass++;
        n_checks++; if (drain_done !== 1'b0) $display("FAIL reset_drain_done got=%0b exp=0", drain_done); else n_pass++;
        n_checks++; if (busy !== 1'b0)       $display("FAIL reset_busy got=%0b exp=0", busy); else n_pass++;
        n_checks++; if (sat_flag !== 1'b0)   $display("FAIL reset_sat_flag got=%0b exp=0", sat_flag); else n_pass++;
        n_checks++; if ({out_addr, out_data} !== '0) $display("FAIL reset_out_bus got=%0d exp=0", out_addr); else n_pass++;
    endtask

    task automatic test_clear_add();
        logic [AD*PW-1:0] d;
        d = rnd_data(); d[PW-1:0] = 24'd100;
        send_beat(5, 1'b1, d);
        d = rnd_data(); d[PW-1:0] = -24'sd30;
        send_beat(5, 1'b0, d);
        idle();
        do_drain(5, 1, 1'b0);
        n_checks++;
        if (last_data[ACW-1:0] !== 32'd70) $display("FAIL clear_add_lane0 got=%0d exp=70", $signed(last_data[ACW-1:0]));
        else n_pass++;
    endtask

    task automatic test_hazard();
        int stalls;
        stalls = 0;
        for (int k = 1; k <= 4; k++) begin
            send_beat(3, (k == 1), rep(PW'(k)));
            if (!psum_ready) stalls++;
        end
        idle();
        n_checks++;
        if (stalls !== 0) $display("FAIL hazard_stall got=%0d exp=0", stalls); else n_pass++;
        do_drain(3, 1, 1'b0);
        n_checks++;
        if (last_data !== {AD{32'd10}}) $display("FAIL hazard_sum got=%h exp=all 10", last_data); else n_pass++;
    endtask

    task automatic test_drain_with_beat();
        @(negedge clk);
        psum_valid  = 1'b1; psum_addr = 7; psum_clear = 1'b1; psum_data = rep(24'd9);
        apply_beat(7, 1'b1, rep(24'd9));
        drain_start = 1'b1; drain_base = 7; drain_len = 1; out_ready = 1'b1;
        $display("beat addr=7 with drain start base=7 len=1");
        @(negedge clk);
        psum_valid  = 1'b0;
        drain_start = 1'b0;
        n_checks++;
        if (psum_ready !== 1'b0) $display("FAIL drain_psum_ready got=%0b exp=0", psum_ready); else n_pass++;
        run_drain(7, 1, 1'b0);
        n_checks++;
        if (last_data !== {AD{32'd9}}) $display("FAIL drain_with_beat got=%h exp=all 9", last_data); else n_pass++;
    endtask

    task automatic test_len0();
        do_drain(11, 0, 1'b0);
    endtask

    task automatic test_random();
        logic [AW-1:0] a;
        for (int e = 0; e < DEPTH; e++) send_beat(AW'(e), 1'b1, rnd_data());
        for (int k = 0; k < 300; k++) begin
            a = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 3)) : AW'($urandom);
            send_beat(a, ($urandom_range(0, 7) == 0), rnd_data());
        end
        idle();
        do_drain($urandom_range(0, DEPTH - 1), DEPTH, 1'b1);
        do_drain($urandom_range(0, DEPTH - 1), $urandom_range(1, 20), 1'b1);
    endtask

    task automatic test_wrap();
        do_drain(62, 4, 1'b1);
    endtask

    task automatic test_sat();
        logic exp_sat;
        logic [ACW-1:0] exp_lane;
`ifdef PSUM_ACC_SAT_EN
        exp_sat  = 1'b1;
        exp_lane = 32'h7FFFFFFF;
`else
        exp_sat  = 1'b0;
        exp_lane = 32'h800000F0;   // 0x7FFFFFF0 + 0x100 wrapped
`endif
        // 256 * 0x7FFFFF + 0xF0 = 0x7FFFFFF0, then add 0x100.
        send_beat(0, 1'b1, rep(24'h7FFFFF));
        for (int k = 0; k < 255; k++) send_beat(0, 1'b0, rep(24'h7FFFFF));
        send_beat(0, 1'b0, rep(24'h0000F0));
        send_beat(0, 1'b0, rep(24'h000100));
        idle();
        @(negedge clk);
        n_checks++;
        if (sat_flag !== exp_sat) $display("FAIL sat_flag_set got=%0b exp=%0b", sat_flag, exp_sat); else n_pass++;
        do_drain(0, 1, 1'b0);
        n_checks++;
        if (last_data !== {AD{exp_lane}}) $display("FAIL sat_value got=%h exp=%h", last_data[ACW-1:0], exp_lane); else n_pass++;
        n_checks++;
        if (sat_flag !== 1'b0) $display("FAIL sat_flag_cleared got=%0b exp=0", sat_flag); else n_pass++;
    endtask

    task automatic test_reset_mid_drain();
        int got;
        int bad;
        for (int e = 0; e < 8; e++) send_beat(AW'(e), 1'b1, rnd_data());
        idle();
        @(negedge clk);
        drain_start = 1'b1; drain_base = 0; drain_len = 8; out_ready = 1'b1;
        got = 0;
        for (int cyc = 0; cyc < 50 && got < 2; cyc++) begin
            @(negedge clk);
            drain_start = 1'b0;
            if (out_valid) got++;
        end
        n_checks++;
        if (got !== 2) $display("FAIL mid_drain_reach got=%0d exp=2", got); else n_pass++;
        #2 rst = 1'b1;
        #1;
        $display("reset asserted during drain");
        n_checks++;
        if ({out_valid, psum_ready, busy} !== 3'b010)
            $display("FAIL mid_reset_outputs got=%b exp=010", {out_valid, psum_ready, busy});
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (drain_done || out_valid) bad++;
        end
        n_checks++;
        if (bad !== 0) $display("FAIL mid_reset_no_done got=%0d exp=0", bad); else n_pass++;
    endtask

    initial begin
        rst = 1'b1; psum_valid = 1'b0; psum_clear = 1'b0; psum_addr = '0; psum_data = '0;
        drain_start = 1'b0; drain_base = '0; drain_len = '0; out_ready = 1'b1;
        last_data = '0;
        test_reset();
        test_clear_add();
        test_hazard();
        test_drain_with_beat();
        test_len0();
        test_random();
        test_wrap();
        test_sat();
        test_reset_mid_drain();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
